// File: rtl/key_cmd_seq.sv
// key_cmd_seq
//   Turns the one-cycle key-detect strobes from the ASCII decoder into
//   registered control for the alarm-clock datapath. It handles these commands:
//   '@' + 4 digits loads the clock time (mm:ss).
//   'a' + 4 digits loads the alarm time.
//   's' starts the clock and CR stops it.
//   'l' toggles the alarm enable and 'n' toggles the LED select.
//   ESC abandons a digit entry.
//   A tens digit must be 0-5 and a ones digit must be 0-9. A digit outside
//   its range is silently ignored.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   det_esc .. det_S          one-cycle key strobes from the decoder
//   key_digit[3:0]            digit value, sampled only when a digit is accepted
//   ld_time, ld_alarm         one-cycle load pulses (cycle after the 4th digit)
//   set_min_t/o, set_sec_t/o  BCD value of the last completed entry
//   run, alarm_en, led_sel    control levels
//   entry_busy, entry_pos     entry in progress / index of next expected digit
module key_cmd_seq #(
    parameter int NDIG = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       det_esc,
    input  logic       det_num,
    input  logic       det_num0to5,
    input  logic       det_cr,
    input  logic       det_atSign,
    input  logic       det_A,
    input  logic       det_L,
    input  logic       det_N,
    input  logic       det_S,
    input  logic [3:0] key_digit,
    output logic       ld_time,
    output logic       ld_alarm,
    output logic [3:0] set_min_t,
    output logic [3:0] set_min_o,
    output logic [3:0] set_sec_t,
    output logic [3:0] set_sec_o,
    output logic       run,
    output logic       alarm_en,
    output logic       led_sel,
    output logic       entry_busy,
    output logic [1:0] entry_pos
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIG  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    localparam logic [1:0] LAST_POS = 2'(NDIG - 1);

    state_t          r_state, w_state_nx;
    logic [1:0]      r_pos, w_pos_nx;
    logic            r_tgt_alarm, w_tgt_alarm_nx;
    logic [2:0][3:0] r_shadow, w_shadow_nx;
    logic [3:0][3:0] r_set, w_set_nx;
    logic            r_run, w_run_nx;
    logic            r_alarm_en, w_alarm_en_nx;
    logic            r_led_sel, w_led_sel_nx;
    logic            r_ld_time, w_ld_time_nx;
    logic            r_ld_alarm, w_ld_alarm_nx;
    logic            r_busy;

    // Resolve simultaneous strobes into at most one winning key. The order is
    // esc > '@' > 'a' > digit > 's' > CR > 'l' > 'n'.
    logic w_k_esc, w_k_at, w_k_a, w_k_dig, w_k_s, w_k_cr, w_k_l, w_k_n;
    logic w_digit_ok;

    always_comb begin
        w_k_esc = det_esc;
        w_k_at  = !w_k_esc && det_atSign;
        w_k_a   = !w_k_esc && !det_atSign && det_A;
        w_k_dig = !w_k_esc && !det_atSign && !det_A && (det_num || det_num0to5);
        w_k_s   = !w_k_esc && !det_atSign && !det_A && !(det_num || det_num0to5) && det_S;
        w_k_cr  = !w_k_esc && !det_atSign && !det_A && !(det_num || det_num0to5) && !det_S && det_cr;
        w_k_l   = !w_k_esc && !det_atSign && !det_A && !(det_num || det_num0to5) && !det_S && !det_cr && det_L;
        w_k_n   = !w_k_esc && !det_atSign && !det_A && !(det_num || det_num0to5) && !det_S && !det_cr && !det_L && det_N;
        // Even positions are tens digits (0-5), odd positions are ones digits (0-9).
        w_digit_ok = r_pos[0] ? det_num : det_num0to5;
    end

    always_comb begin
        w_state_nx     = r_state;
        w_pos_nx       = r_pos;
        w_tgt_alarm_nx = r_tgt_alarm;
        w_shadow_nx    = r_shadow;
        w_set_nx       = r_set;
        w_run_nx       = r_run;
        w_alarm_en_nx  = r_alarm_en;
        w_led_sel_nx   = r_led_sel;
        w_ld_time_nx   = 1'b0;
        w_ld_alarm_nx  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_k_at || w_k_a) begin
                    w_state_nx     = ST_DIG;
                    w_pos_nx       = 2'd0;
                    w_tgt_alarm_nx = w_k_a;
                    w_shadow_nx    = '0;
                end
                if (w_k_s)  w_run_nx      = 1'b1;
                if (w_k_cr) w_run_nx      = 1'b0;
                if (w_k_l)  w_alarm_en_nx = !r_alarm_en;
                if (w_k_n)  w_led_sel_nx  = !r_led_sel;
            end

            ST_DIG: begin
                if (w_k_esc) begin
                    w_state_nx = ST_IDLE;
                    w_pos_nx   = 2'd0;
                end else if (w_k_at || w_k_a) begin
                    // Restart with the new target; earlier digits are dropped.
                    w_pos_nx       = 2'd0;
                    w_tgt_alarm_nx = w_k_a;
                    w_shadow_nx    = '0;
                end else if (w_k_dig && w_digit_ok) begin
                    if (r_pos == LAST_POS) begin
                        // The final digit goes straight to the outputs.
                        w_state_nx    = ST_LOAD;
                        w_pos_nx      = 2'd0;
                        w_set_nx      = {r_shadow[0], r_shadow[1], r_shadow[2], key_digit};
                        w_ld_time_nx  = !r_tgt_alarm;
                        w_ld_alarm_nx = r_tgt_alarm;
                    end else begin
                        case (r_pos)
                            2'd0:    w_shadow_nx[0] = key_digit;
                            2'd1:    w_shadow_nx[1] = key_digit;
                            default: w_shadow_nx[2] = key_digit;
                        endcase
                        w_pos_nx = r_pos + 2'd1;
                    end
                end
            end

            ST_LOAD: begin
                w_state_nx = ST_IDLE;
            end

            default: begin
                w_state_nx = ST_IDLE;
                w_pos_nx   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pos       <= 2'd0;
            r_tgt_alarm <= 1'b0;
            r_shadow    <= '0;
            r_set       <= '0;
            r_run       <= 1'b0;
            r_alarm_en  <= 1'b0;
            r_led_sel   <= 1'b0;
            r_ld_time   <= 1'b0;
            r_ld_alarm  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_pos       <= w_pos_nx;
            r_tgt_alarm <= w_tgt_alarm_nx;
            r_shadow    <= w_shadow_nx;
            r_set       <= w_set_nx;
            r_run       <= w_run_nx;
            r_alarm_en  <= w_alarm_en_nx;
            r_led_sel   <= w_led_sel_nx;
            r_ld_time   <= w_ld_time_nx;
            r_ld_alarm  <= w_ld_alarm_nx;
            r_busy      <= (w_state_nx == ST_DIG);
        end
    end

    assign ld_time    = r_ld_time;
    assign ld_alarm   = r_ld_alarm;
    assign set_min_t  = r_set[3];
    assign set_min_o  = r_set[2];
    assign set_sec_t  = r_set[1];
    assign set_sec_o  = r_set[0];
    assign run        = r_run;
    assign alarm_en   = r_alarm_en;
    assign led_sel    = r_led_sel;
    assign entry_busy = r_busy;
    // r_pos is forced to 0 on every exit from DIG.
    assign entry_pos  = r_pos;

endmodule

// File: tb/tb_key_cmd_seq.sv
module tb_key_cmd_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       det_esc, det_num, det_num0to5, det_cr, det_atSign;
    logic       det_A, det_L, det_N, det_S;
    logic [3:0] key_digit;
    logic       ld_time, ld_alarm, run, alarm_en, led_sel, entry_busy;
    logic [3:0] set_min_t, set_min_o, set_sec_t, set_sec_o;
    logic [1:0] entry_pos;

    key_cmd_seq #(.NDIG(4)) dut (
        .clk(clk), .rst(rst),
        .det_esc(det_esc), .det_num(det_num), .det_num0to5(det_num0to5),
        .det_cr(det_cr), .det_atSign(det_atSign), .det_A(det_A),
        .det_L(det_L), .det_N(det_N), .det_S(det_S), .key_digit(key_digit),
        .ld_time(ld_time), .ld_alarm(ld_alarm),
        .set_min_t(set_min_t), .set_min_o(set_min_o),
        .set_sec_t(set_sec_t), .set_sec_o(set_sec_o),
        .run(run), .alarm_en(alarm_en), .led_sel(led_sel),
        .entry_busy(entry_busy), .entry_pos(entry_pos)
    );

    always #5 clk = ~clk;

    // {ld_time, ld_alarm, run, alarm_en, led_sel, entry_busy, entry_pos, mm:ss}
    wire [23:0] w_act = {ld_time, ld_alarm, run, alarm_en, led_sel, entry_busy,
                         entry_pos, set_min_t, set_min_o, set_sec_t, set_sec_o};

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    bit         m_in_entry, m_tgt_alarm, m_ldt, m_lda, m_run, m_aen, m_led;
    int         m_digs[$];
    logic [3:0] m_set[4];

    // strobe vector bits: 8 esc, 7 num, 6 num0to5, 5 cr, 4 '@', 3 'a', 2 'l', 1 'n', 0 's'
    function automatic void model_step(input logic [8:0] s, input logic [3:0] d, input bit r);
        bit esc = s[8];
        bit dig = s[7] | s[6];
        bit was_load = m_ldt | m_lda;
        m_ldt = 0;
        m_lda = 0;
        if (r) begin
            m_in_entry = 0; m_tgt_alarm = 0; m_run = 0; m_aen = 0; m_led = 0;
            m_digs.delete();
            for (int i = 0; i < 4; i++) m_set[i] = 4'd0;
            return;
        end
        if (was_load) return;
        if (!m_in_entry) begin
            if (esc) begin end
            else if (s[4] || s[3]) begin
                m_in_entry = 1; m_tgt_alarm = !s[4]; m_digs.delete();
            end
            else if (dig) begin end
            else if (s[0]) m_run = 1;
            else if (s[5]) m_run = 0;
            else if (s[2]) m_aen = !m_aen;
            else if (s[1]) m_led = !m_led;
        end else begin
            if (esc) begin
                m_in_entry = 0; m_digs.delete();
            end else if (s[4] || s[3]) begin
                m_tgt_alarm = !s[4]; m_digs.delete();
            end else if (dig) begin
                bit ok = (m_digs.size() % 2 == 0) ? s[6] : s[7];
                if (ok) begin
                    m_digs.push_back(int'(d));
                    if (m_digs.size() == 4) begin
                        for (int i = 0; i < 4; i++) m_set[i] = 4'(m_digs[i]);
                        m_in_entry = 0;
                        m_digs.delete();
                        if (m_tgt_alarm) m_lda = 1; else m_ldt = 1;
                    end
                end
            end
        end
    endfunction

    function automatic logic [23:0] m_pack();
        logic [1:0] p = m_in_entry ? 2'(m_digs.size()) : 2'd0;
        return {m_ldt, m_lda, m_run, m_aen, m_led, m_in_entry, p,
                m_set[0], m_set[1], m_set[2], m_set[3]};
    endfunction

    function automatic logic [23:0] E(bit lt, bit la, bit ru, bit ae, bit le, bit bu,
                                      logic [1:0] p, logic [15:0] st);
        return {lt, la, ru, ae, le, bu, p, st};
    endfunction

    // ---------------- drivers / checker ----------------
    task automatic cycle(input logic [8:0] s, input logic [3:0] d, input bit r);
        {det_esc, det_num, det_num0to5, det_cr, det_atSign, det_A, det_L, det_N, det_S} = s;
        key_digit = d;
        rst = r;
        model_step(s, d, r);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [23:0] exp);
        checks++;
        if (w_act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, w_act, exp);
        end
    endtask

    task automatic key_to_stb(input byte k, output logic [8:0] s, output logic [3:0] d, output bit r);
        s = '0;
        d = 4'($urandom_range(0, 15));
        r = 0;
        case (k)
            "R":   r = 1;
            8'd27: s[8] = 1;
            "@":   s[4] = 1;
            "a":   s[3] = 1;
            "s":   s[0] = 1;
            8'd13: s[5] = 1;
            "l":   s[2] = 1;
            "n":   s[1] = 1;
            default: begin
                if (k >= "0" && k <= "9") begin
                    d = 4'(k - "0");
                    s[7] = 1;
                    s[6] = (k <= "5");
                end
            end
        endcase
    endtask

    typedef struct {
        byte        k;
        logic [23:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(byte k, logic [23:0] e);
        vec_t v;
        v.k = k;
        v.exp = e;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [8:0] s;
        logic [3:0] d;
        bit         r;
        int         pick[7] = '{8, 5, 4, 3, 2, 1, 0};

        // '@1234' with idle gaps -> ld_time, one cycle after '4'
        add("@", E(0,0,0,0,0,1,0,16'h0000));
        add("1", E(0,0,0,0,0,1,1,16'h0000));
        add(0,   E(0,0,0,0,0,1,1,16'h0000));
        add("2", E(0,0,0,0,0,1,2,16'h0000));
        add("3", E(0,0,0,0,0,1,3,16'h0000));
        add(0,   E(0,0,0,0,0,1,3,16'h0000));
        add("4", E(1,0,0,0,0,0,0,16'h1234));
        add(0,   E(0,0,0,0,0,0,0,16'h1234));
        // 'a659907': '6' and second '9' rejected as tens digits
        add("a", E(0,0,0,0,0,1,0,16'h1234));
        add("6", E(0,0,0,0,0,1,0,16'h1234));
        add("5", E(0,0,0,0,0,1,1,16'h1234));
        add("9", E(0,0,0,0,0,1,2,16'h1234));
        add("9", E(0,0,0,0,0,1,2,16'h1234));
        add("0", E(0,0,0,0,0,1,3,16'h1234));
        add("7", E(0,1,0,0,0,0,0,16'h5907));
        add(0,   E(0,0,0,0,0,0,0,16'h5907));
        // '@12' ESC -> abort, values kept
        add("@",   E(0,0,0,0,0,1,0,16'h5907));
        add("1",   E(0,0,0,0,0,1,1,16'h5907));
        add("2",   E(0,0,0,0,0,1,2,16'h5907));
        add(8'd27, E(0,0,0,0,0,0,0,16'h5907));
        add(0,     E(0,0,0,0,0,0,0,16'h5907));
        // '@1a3000' -> restart as alarm entry
        add("@", E(0,0,0,0,0,1,0,16'h5907));
        add("1", E(0,0,0,0,0,1,1,16'h5907));
        add("a", E(0,0,0,0,0,1,0,16'h5907));
        add("3", E(0,0,0,0,0,1,1,16'h5907));
        add("0", E(0,0,0,0,0,1,2,16'h5907));
        add("0", E(0,0,0,0,0,1,3,16'h5907));
        add("0", E(0,1,0,0,0,0,0,16'h3000));
        add(0,   E(0,0,0,0,0,0,0,16'h3000));
        // levels
        add("s",   E(0,0,1,0,0,0,0,16'h3000));
        add("l",   E(0,0,1,1,0,0,0,16'h3000));
        add("l",   E(0,0,1,0,0,0,0,16'h3000));
        add("n",   E(0,0,1,0,1,0,0,16'h3000));
        add(8'd13, E(0,0,0,0,1,0,0,16'h3000));
        add("@",   E(0,0,0,0,1,1,0,16'h3000));
        add("s",   E(0,0,0,0,1,1,0,16'h3000));
        add(8'd27, E(0,0,0,0,1,0,0,16'h3000));
        // strobe during LOAD ignored
        add("@", E(0,0,0,0,1,1,0,16'h3000));
        add("1", E(0,0,0,0,1,1,1,16'h3000));
        add("2", E(0,0,0,0,1,1,2,16'h3000));
        add("3", E(0,0,0,0,1,1,3,16'h3000));
        add("4", E(1,0,0,0,1,0,0,16'h1234));
        add("s", E(0,0,0,0,1,0,0,16'h1234));
        add(0,   E(0,0,0,0,1,0,0,16'h1234));
        // reset mid-entry
        add("@", E(0,0,0,0,1,1,0,16'h1234));
        add("1", E(0,0,0,0,1,1,1,16'h1234));
        add("2", E(0,0,0,0,1,1,2,16'h1234));
        add("R", E(0,0,0,0,0,0,0,16'h0000));
        add("3", E(0,0,0,0,0,0,0,16'h0000));
        add("4", E(0,0,0,0,0,0,0,16'h0000));
        add(0,   E(0,0,0,0,0,0,0,16'h0000));

        cycle('0, 4'd0, 1);
        cycle('0, 4'd0, 1);
        check("reset", 24'h000000);

        foreach (tbl[i]) begin
            key_to_stb(tbl[i].k, s, d, r);
            cycle(s, d, r);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Simultaneous strobes resolved by priority
        cycle('0, 4'd0, 1);
        cycle(9'h011, 4'd0, 0); check("prio_at_over_s", E(0,0,0,0,0,1,0,16'h0000));
        cycle(9'h110, 4'd0, 0); check("prio_esc_over_at", E(0,0,0,0,0,0,0,16'h0000));
        cycle(9'h021, 4'd0, 0); check("prio_s_over_cr", E(0,0,1,0,0,0,0,16'h0000));
        cycle(9'h006, 4'd0, 0); check("prio_l_over_n", E(0,0,1,1,0,0,0,16'h0000));
        cycle(9'h0A0, 4'd7, 0); check("prio_dig_over_cr", E(0,0,1,1,0,0,0,16'h0000));

        // Randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            int c = $urandom_range(0, 31);
            s = '0;
            d = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 99) == 0);
            if (c < 16) begin
                d = 4'($urandom_range(0, 9));
                s[7] = 1;
                s[6] = (d <= 4'd5);
            end else if (c < 18) s[4] = 1;
            else if (c < 20) s[3] = 1;
            else if (c == 20) s[8] = 1;
            else if (c == 21) s[0] = 1;
            else if (c == 22) s[5] = 1;
            else if (c == 23) s[2] = 1;
            else if (c == 24) s[1] = 1;
            if ($urandom_range(0, 15) == 0) s[pick[$urandom_range(0, 6)]] = 1;
            cycle(s, d, r);
            check($sformatf("rand%0d", n), m_pack());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
